// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl
//   Raster-scan generator and VGA pin driver. Produces the scan position
//   (hcount/vcount) plus vsync, frame and blank aligned with it. It accepts
//   the RGB332 pixel that the game logic returns PIXEL_LAT clocks later. The
//   raw syncs and blank are delayed by PIXEL_LAT stages so that they meet that
//   pixel in the registered output stage.
//
// Ports
//   vclk    in   pixel clock
//   rst     in   asynchronous active-low reset
//   pixel   in   [7:5] red, [4:2] green, [1:0] blue
//   hcount  out  horizontal position 0..H_TOTAL-1
//   vcount  out  line 0..V_TOTAL-1
//   vsync   out  vertical sync aligned with the counts, polarity applied
//   frame   out  one-clock pulse at (0, V_ACTIVE): start of vertical blank
//   blank   out  1 outside the visible area, aligned with the counts
//   vga_hs  out  registered hsync pin, delayed to match RGB
//   vga_vs  out  registered vsync pin, delayed to match RGB
//   vga_r   out  registered red
//   vga_g   out  registered green
//   vga_b   out  registered blue
module vga_display_ctrl #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BP      = 64,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 23,
    parameter bit SYNC_POL  = 1'b1,
    parameter int PIXEL_LAT = 1
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic [7:0]  pixel,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        vsync,
    output logic        frame,
    output logic        blank,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [1:0]  vga_b
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if (PIXEL_LAT < 0 || PIXEL_LAT > 4 ||
            H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
            $error("vga_display_ctrl: PIXEL_LAT must be 0..4 and all timing fields non-zero");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        hs_raw;   // active-true, aligned with the counts
    logic        vs_raw;

    always_comb begin
        h_nxt = hcount + 11'd1;
        v_nxt = vcount;
        if (hcount == 11'(H_TOTAL - 1)) begin
            h_nxt = 11'd0;
            v_nxt = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        end
    end

    // The flags are computed from the next count values so that, once
    // registered, they describe the same position as hcount/vcount.
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            hcount <= 11'd0;
            vcount <= 10'd0;
            hs_raw <= 1'b0;
            vs_raw <= 1'b0;
            blank  <= 1'b0;
            frame  <= 1'b0;
        end else begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hs_raw <= (h_nxt >= 11'(HS_START)) && (h_nxt < 11'(HS_END));
            vs_raw <= (v_nxt >= 10'(VS_START)) && (v_nxt < 10'(VS_END));
            blank  <= (h_nxt >= 11'(H_ACTIVE)) || (v_nxt >= 10'(V_ACTIVE));
            frame  <= (h_nxt == 11'd0) && (v_nxt == 10'(V_ACTIVE));
        end
    end

    assign vsync = SYNC_POL ? vs_raw : ~vs_raw;

    // ------------------------------------------------------------------
    // Delay line: PIXEL_LAT stages, so that sync/blank meet the pixel that
    // belongs to the same position at the output register.
    // ------------------------------------------------------------------
    logic d_hs, d_vs, d_blank;

    generate
        if (PIXEL_LAT == 0) begin : g_no_dly
            assign d_hs    = hs_raw;
            assign d_vs    = vs_raw;
            assign d_blank = blank;
        end else begin : g_dly
            logic [PIXEL_LAT-1:0] p_hs, p_vs, p_blank;

            always_ff @(posedge vclk or negedge rst) begin
                if (!rst) begin
                    p_hs    <= '0;
                    p_vs    <= '0;
                    p_blank <= '1;
                end else begin
                    p_hs    <= (p_hs    << 1) | PIXEL_LAT'(hs_raw);
                    p_vs    <= (p_vs    << 1) | PIXEL_LAT'(vs_raw);
                    p_blank <= (p_blank << 1) | PIXEL_LAT'(blank);
                end
            end

            assign d_hs    = p_hs[PIXEL_LAT-1];
            assign d_vs    = p_vs[PIXEL_LAT-1];
            assign d_blank = p_blank[PIXEL_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
            vga_r  <= 3'd0;
            vga_g  <= 3'd0;
            vga_b  <= 2'd0;
        end else begin
            vga_hs <= SYNC_POL ? d_hs : ~d_hs;
            vga_vs <= SYNC_POL ? d_vs : ~d_vs;
            vga_r  <= d_blank ? 3'd0 : pixel[7:5];
            vga_g  <= d_blank ? 3'd0 : pixel[4:2];
            vga_b  <= d_blank ? 2'd0 : pixel[1:0];
        end
    end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb_vga_display_ctrl
//   Two instances with a shrunken raster: one with PIXEL_LAT=2 and
//   active-high sync, and one with PIXEL_LAT=0 and active-low sync. Random
//   pixels are driven. Every output is compared each clock against a model
//   that derives the scan position from the number of clocks since reset
//   release.
module tb_vga_display_ctrl;

    localparam int HA = 16, HF = 3, HS = 4, HB = 5;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 28
    localparam int VT = VA + VF + VS + VB;   // 17
    localparam int FT = HT * VT;             // 476
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic vclk = 1'b0;
    logic rst  = 1'b0;
    logic [7:0] pix_a = 8'd0, pix_b = 8'd0;

    logic [10:0] a_h, b_h;
    logic [9:0]  a_v, b_v;
    logic a_vsync, a_frame, a_blank, a_hs, a_vs;
    logic b_vsync, b_frame, b_blank, b_hs, b_vs;
    logic [2:0] a_r, a_g, b_r, b_g;
    logic [1:0] a_b, b_b;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;          // clocks since reset release
    logic [7:0] prev_a = 8'd0, prev_b = 8'd0;
    int frame_pos[$];

    always #5 vclk = ~vclk;

    vga_display_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                       .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                       .SYNC_POL(1'b1), .PIXEL_LAT(LAT_A)) u_a (
        .vclk(vclk), .rst(rst), .pixel(pix_a), .hcount(a_h), .vcount(a_v),
        .vsync(a_vsync), .frame(a_frame), .blank(a_blank), .vga_hs(a_hs),
        .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b));

    vga_display_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                       .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                       .SYNC_POL(1'b0), .PIXEL_LAT(LAT_B)) u_b (
        .vclk(vclk), .rst(rst), .pixel(pix_b), .hcount(b_h), .vcount(b_v),
        .vsync(b_vsync), .frame(b_frame), .blank(b_blank), .vga_hs(b_hs),
        .vga_vs(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at n=%0d: observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic check_rst(input string id, input bit pol,
                             input logic [10:0] h, input logic [9:0] v,
                             input logic vsy, input logic fr, input logic bl,
                             input logic hp, input logic vp, input logic [7:0] rgb);
        chk({id, " rst hcount"}, 32'(h), 0);
        chk({id, " rst vcount"}, 32'(v), 0);
        chk({id, " rst frame"},  32'(fr), 0);
        chk({id, " rst blank"},  32'(bl), 0);
        chk({id, " rst vsync"},  32'(vsy), 32'(!pol));
        chk({id, " rst vga_hs"}, 32'(hp), 32'(!pol));
        chk({id, " rst vga_vs"}, 32'(vp), 32'(!pol));
        chk({id, " rst rgb"},    32'(rgb), 0);
    endtask

    // Model: position at clock k after release is (k mod HT, (k div HT) mod VT).
    // Pins at clock k show the position from k-lat-1 and the pixel driven
    // during clock k-1.
    task automatic check_run(input string id, input int lat, input bit pol,
                             input logic [7:0] pprev,
                             input logic [10:0] h, input logic [9:0] v,
                             input logic vsy, input logic fr, input logic bl,
                             input logic hp, input logic vp, input logic [7:0] rgb);
        int eh, ev, k, kh, kv;
        bit vs_act, hs_pin, vs_pin;
        logic [7:0] e_rgb;
        eh = n % HT;
        ev = (n / HT) % VT;
        vs_act = (ev >= VA + VF) && (ev < VA + VF + VS);
        chk({id, " hcount"}, 32'(h), 32'(eh));
        chk({id, " vcount"}, 32'(v), 32'(ev));
        chk({id, " frame"},  32'(fr), 32'(eh == 0 && ev == VA));
        chk({id, " blank"},  32'(bl), 32'(eh >= HA || ev >= VA));
        chk({id, " vsync"},  32'(vsy), 32'(pol ? vs_act : !vs_act));
        k = n - lat - 1;
        hs_pin = 1'b0;
        vs_pin = 1'b0;
        e_rgb  = 8'd0;
        if (k >= 0) begin
            kh = k % HT;
            kv = (k / HT) % VT;
            hs_pin = (kh >= HA + HF) && (kh < HA + HF + HS);
            vs_pin = (kv >= VA + VF) && (kv < VA + VF + VS);
            if (kh < HA && kv < VA) e_rgb = pprev;
        end
        chk({id, " vga_hs"}, 32'(hp), 32'(pol ? hs_pin : !hs_pin));
        chk({id, " vga_vs"}, 32'(vp), 32'(pol ? vs_pin : !vs_pin));
        chk({id, " rgb"},    32'(rgb), 32'(e_rgb));
    endtask

    // One clock per iteration: check at the negedge, then drive a new pixel.
    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_run("A", LAT_A, 1'b1, prev_a, a_h, a_v, a_vsync, a_frame, a_blank,
                      a_hs, a_vs, {a_r, a_g, a_b});
            check_run("B", LAT_B, 1'b0, prev_b, b_h, b_v, b_vsync, b_frame, b_blank,
                      b_hs, b_vs, {b_r, b_g, b_b});
            if (a_frame === 1'b1) frame_pos.push_back(n);
            pix_a  = 8'($urandom);
            pix_b  = 8'($urandom);
            prev_a = pix_a;
            prev_b = pix_b;
            @(negedge vclk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b0;
        pix_a = 8'hFF;
        pix_b = 8'hFF;
        repeat (3) @(negedge vclk);
        check_rst("A", 1'b1, a_h, a_v, a_vsync, a_frame, a_blank, a_hs, a_vs, {a_r, a_g, a_b});
        check_rst("B", 1'b0, b_h, b_v, b_vsync, b_frame, b_blank, b_hs, b_vs, {b_r, b_g, b_b});

        // Release and free-run two frames plus a margin.
        rst = 1'b1;
        n = 0;
        run(2 * FT + 40);
        chk("frame count", 32'(frame_pos.size()), 2);
        if (frame_pos.size() == 2) begin
            chk("frame first pos", 32'(frame_pos[0]), 32'(VA * HT));
            chk("frame spacing", 32'(frame_pos[1] - frame_pos[0]), 32'(FT));
        end

        // Reset mid-frame at a random point, asserted between clock edges.
        run($urandom_range(HT * 2, FT - HT * 2));
        #2 rst = 1'b0;
        #1;
        check_rst("A", 1'b1, a_h, a_v, a_vsync, a_frame, a_blank, a_hs, a_vs, {a_r, a_g, a_b});
        check_rst("B", 1'b0, b_h, b_v, b_vsync, b_frame, b_blank, b_hs, b_vs, {b_r, b_g, b_b});
        @(negedge vclk);
        check_rst("A", 1'b1, a_h, a_v, a_vsync, a_frame, a_blank, a_hs, a_vs, {a_r, a_g, a_b});
        rst = 1'b1;
        n = 0;
        frame_pos.delete();
        run(FT + 30);
        chk("post-reset frame count", 32'(frame_pos.size()), 1);
        if (frame_pos.size() >= 1)
            chk("post-reset frame pos", 32'(frame_pos[0]), 32'(VA * HT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
